// File: rtl/ship_input_gen_pkg.sv
// Shared raster constants, button defaults and small helpers for the ship input front end.
package ship_input_gen_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;

  localparam int unsigned COORD_W        = 10;
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

  // Frame-latched direction set, MSB first as {up, down, left, right}.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Counter width that stays legal when the modulus is 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ship_input_gen_btn_debounce.sv
// Two-flop synchroniser plus hold-time debouncer for one raw button; rise pulses
// for one clk when the accepted level goes high.
module btn_debounce
  import ship_input_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned      CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted only after it has disagreed with level for DEB_CYCLES clks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ship_input_gen.sv
// Button front end for the ship mover: debounced frame-latched directions,
// a pause toggle and a move strobe issued once every SPEED_DIV frames.
module ship_input_gen
  import ship_input_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned SPEED_DIV  = 1,
  parameter int unsigned MOVE_H     = 0,
  parameter int unsigned MOVE_V     = 481
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixpulse,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               btnU,
  input  logic               btnD,
  input  logic               btnL,
  input  logic               btnR,
  input  logic               btnC,
  output logic               mU,
  output logic               mD,
  output logic               mL,
  output logic               mR,
  output logic               move,
  output logic               paused
);

  localparam int unsigned      DIV_W    = cnt_width(SPEED_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);

  logic [3:0]       dir_raw;
  logic [3:0]       dir_level;
  logic [3:0]       dir_rise_unused;
  logic             pause_level_unused;
  logic             pause_rise;
  dir_t             dir_now;
  logic [DIV_W-1:0] div;
  logic             at_move_c;
  logic             at_origin_c;

  assign dir_raw     = {btnU, btnD, btnL, btnR};
  assign dir_now     = dir_t'(dir_level);
  assign at_move_c   = (hcount == COORD_W'(MOVE_H)) && (vcount == COORD_W'(MOVE_V));
  assign at_origin_c = (hcount == '0) && (vcount == '0);

  for (genvar i = 0; i < 4; i++) begin : g_dir
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (dir_raw[i]),
      .level(dir_level[i]),
      .rise (dir_rise_unused[i])
    );
  end

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk  (clk),
    .rst  (rst),
    .raw  (btnC),
    .level(pause_level_unused),
    .rise (pause_rise)
  );

  // move samples the pre-toggle paused value, so a same-clk toggle never leaks through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mU     <= 1'b0;
      mD     <= 1'b0;
      mL     <= 1'b0;
      mR     <= 1'b0;
      move   <= 1'b0;
      paused <= 1'b0;
      div    <= '0;
    end else begin
      if (pause_rise) begin
        paused <= ~paused;
      end
      if (pixpulse) begin
        move <= at_move_c && (div == '0) && !paused;
        if (at_move_c) begin
          div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
        if (at_origin_c) begin
          mU <= dir_now.up;
          mD <= dir_now.down;
          mL <= dir_now.left;
          mR <= dir_now.right;
        end
      end
    end
  end

endmodule

// File: tb/tb_ship_input_gen.sv
// Bench for ship_input_gen on a shrunken raster, with a frame-level reference model
// and a second instance running at SPEED_DIV=1.
module tb_ship_input_gen;

  localparam int DEB   = 8;
  localparam int SPD   = 3;
  localparam int MH    = 3;
  localparam int MV    = 8;
  localparam int HT    = 20;
  localparam int VT    = 10;
  localparam int FRAME = HT * VT * 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       pixpulse = 1'b0;
  logic [9:0] hcount   = 10'd0;
  logic [9:0] vcount   = 10'd0;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
  logic       mU, mD, mL, mR, move, paused;
  logic       mU1, mD1, mL1, mR1, move1, paused1;

  int checks   = 0;
  int failures = 0;
  int ph       = 0;

  always #5 clk = ~clk;

  ship_input_gen #(.DEB_CYCLES(DEB), .SPEED_DIV(SPD), .MOVE_H(MH), .MOVE_V(MV)) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .mU(mU), .mD(mD), .mL(mL), .mR(mR), .move(move), .paused(paused)
  );

  ship_input_gen #(.DEB_CYCLES(DEB), .SPEED_DIV(1), .MOVE_H(MH), .MOVE_V(MV)) dut1 (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .mU(mU1), .mD(mD1), .mL(mL1), .mR(mR1), .move(move1), .paused(paused1)
  );

  // Upstream VGA timing: pixpulse one clk in four, raster advances on each pixpulse.
  always @(posedge clk) begin
    ph       <= (ph + 1) % 4;
    pixpulse <= (ph == 3);
    if (pixpulse) begin
      if (hcount == 10'(HT - 1)) begin
        hcount <= 10'd0;
        vcount <= (vcount == 10'(VT - 1)) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Reference model: buttons are {C,U,D,L,R}; a level is accepted once the 2-clk-delayed
  // input has disagreed with it for DEB consecutive clks; moves are numbered per frame.
  logic [4:0] raw_vec;
  logic [4:0] m_pipe1, m_pipe2, m_lvl;
  int         m_run [5];
  logic       m_rise_pend, m_paused, m_move, m_move1;
  logic [3:0] m_dirs;
  int         m_moves_seen;

  assign raw_vec = {btnC, btnU, btnD, btnL, btnR};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pipe1 <= 5'd0; m_pipe2 <= 5'd0; m_lvl <= 5'd0;
      for (int i = 0; i < 5; i++) m_run[i] <= 0;
      m_rise_pend <= 1'b0; m_paused <= 1'b0; m_move <= 1'b0; m_move1 <= 1'b0;
      m_dirs <= 4'd0; m_moves_seen <= 0;
    end else begin
      if (pixpulse) begin
        if (hcount == 10'(MH) && vcount == 10'(MV)) begin
          m_move       <= ((m_moves_seen % SPD) == 0) && !m_paused;
          m_move1      <= !m_paused;
          m_moves_seen <= m_moves_seen + 1;
        end else begin
          m_move  <= 1'b0;
          m_move1 <= 1'b0;
        end
        if (hcount == 10'd0 && vcount == 10'd0) m_dirs <= m_lvl[3:0];
      end
      if (m_rise_pend) m_paused <= !m_paused;
      m_rise_pend <= 1'b0;
      m_pipe1 <= raw_vec;
      m_pipe2 <= m_pipe1;
      for (int i = 0; i < 5; i++) begin
        if (m_pipe2[i] == m_lvl[i]) m_run[i] <= 0;
        else if (m_run[i] + 1 == DEB) begin
          m_lvl[i] <= m_pipe2[i];
          m_run[i] <= 0;
          if (i == 4 && m_pipe2[i]) m_rise_pend <= 1'b1;
        end else m_run[i] <= m_run[i] + 1;
      end
    end
  end

  logic [11:0] got, exp;
  assign got = {mU, mD, mL, mR, move, paused, mU1, mD1, mL1, mR1, move1, paused1};
  assign exp = {m_dirs, m_move, m_paused, m_dirs, m_move1, m_paused};

  task automatic goto_raster(input int v, input int h);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vcount == 10'(v) && hcount == 10'(h)) && n < 2 * FRAME);
    if (n >= 2 * FRAME) begin
      failures++;
      $display("FAIL raster_wait: v=%0d h=%0d not reached", v, h);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (got !== 12'd0) begin
        failures++;
        $display("FAIL reset_hold: outputs=%b required=%b", got, 12'd0);
      end
    end
  endtask

  task automatic test_first_move;
    int n = 0;
    int w = 0;
    goto_raster(2, 0);
    rst = 1'b1;
    while (!move && n < FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!move) begin
      failures++;
      $display("FAIL first_move: move=%b required=1 within one frame", move);
    end else begin
      checks += 3;
      if (vcount !== 10'(MV)) begin
        failures++;
        $display("FAIL first_move_v: vcount=%0d required=%0d", vcount, MV);
      end
      if (hcount !== 10'(MH + 1)) begin
        failures++;
        $display("FAIL first_move_h: hcount=%0d required=%0d", hcount, MH + 1);
      end
      if (move1 !== 1'b1) begin
        failures++;
        $display("FAIL first_move_div1: move1=%b required=1", move1);
      end
      while (move && w < 8) begin
        w++;
        @(negedge clk);
      end
      checks++;
      if (w != 4) begin
        failures++;
        $display("FAIL first_move_width: clks=%0d required=4", w);
      end
    end
  endtask

  task automatic test_debounce;
    int lens [2] = '{5, 7};
    foreach (lens[k]) begin
      goto_raster(2, 0);
      btnR = 1'b1;
      repeat (lens[k]) @(negedge clk);
      btnR = 1'b0;
      goto_raster(VT / 2, 0);
      goto_raster(0, 1);
      checks++;
      if (mR !== 1'b0) begin
        failures++;
        $display("FAIL glitch_%0d: mR=%b required=0", lens[k], mR);
      end
    end
    goto_raster(2, 0);
    btnR = 1'b1;
    goto_raster(VT - 1, HT - 1);
    checks++;
    if (mR !== 1'b0) begin
      failures++;
      $display("FAIL hold_before_latch: mR=%b required=0", mR);
    end
    goto_raster(0, 1);
    checks++;
    if (mR !== 1'b1 || mR1 !== 1'b1) begin
      failures++;
      $display("FAIL hold_after_latch: mR=%b mR1=%b required=1", mR, mR1);
    end
    btnR = 1'b0;
    goto_raster(VT / 2, 0);
    goto_raster(0, 1);
  endtask

  task automatic test_frame_latch;
    goto_raster(5, 0);
    btnL = 1'b1;
    goto_raster(VT - 1, HT - 1);
    checks++;
    if (mL !== 1'b0) begin
      failures++;
      $display("FAIL latch_same_frame: mL=%b required=0", mL);
    end
    goto_raster(0, 1);
    checks++;
    if (mL !== 1'b1) begin
      failures++;
      $display("FAIL latch_next_frame: mL=%b required=1", mL);
    end
    goto_raster(5, 0);
    btnL = 1'b0;
    goto_raster(VT - 1, HT - 1);
    checks++;
    if (mL !== 1'b1) begin
      failures++;
      $display("FAIL latch_release_hold: mL=%b required=1", mL);
    end
    goto_raster(0, 1);
    checks++;
    if (mL !== 1'b0) begin
      failures++;
      $display("FAIL latch_release_next: mL=%b required=0", mL);
    end
  endtask

  task automatic test_opposing;
    logic [3:0] pats [4] = '{4'b1100, 4'b0011, 4'b1111, 4'b0000};
    foreach (pats[k]) begin
      goto_raster(2, 0);
      {btnU, btnD, btnL, btnR} = pats[k];
      goto_raster(VT / 2, 0);
      goto_raster(0, 1);
      checks++;
      if ({mU, mD, mL, mR} !== pats[k]) begin
        failures++;
        $display("FAIL opposing: dirs=%b required=%b", {mU, mD, mL, mR}, pats[k]);
      end
    end
  endtask

  task automatic test_random;
    int left = 0;
    for (int c = 0; c < 8 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_model: cycle=%0d outputs=%b required=%b", c, got, exp);
      end
      if (left == 0) begin
        {btnC, btnU, btnD, btnL, btnR} = 5'($urandom);
        left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9))
                                           : int'($urandom_range(10, 200));
      end else begin
        left--;
      end
    end
    {btnC, btnU, btnD, btnL, btnR} = 5'd0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_divider;
    int rises [$];
    int n1 = 0;
    int w = 0;
    logic prev = 1'b0;
    logic prev1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    goto_raster(0, 5);
    rst = 1'b1;
    for (int c = 0; c < 7 * FRAME; c++) begin
      @(negedge clk);
      if (move && !prev) rises.push_back(c);
      if (move1 && !prev1) n1++;
      prev  = move;
      prev1 = move1;
      if (move) w++;
      else if (w != 0) begin
        checks++;
        if (w != 4) begin
          failures++;
          $display("FAIL divider_width: clks=%0d required=4", w);
        end
        w = 0;
      end
    end
    checks += 2;
    if (n1 != 7) begin
      failures++;
      $display("FAIL divider_speed1: moves=%0d required=7", n1);
    end
    if (rises.size() != 3) begin
      failures++;
      $display("FAIL divider_count: moves=%0d required=3", rises.size());
    end else begin
      checks += 3;
      if (rises[0] >= FRAME) begin
        failures++;
        $display("FAIL divider_frame0: first=%0d required<%0d", rises[0], FRAME);
      end
      if (rises[1] - rises[0] != 3 * FRAME) begin
        failures++;
        $display("FAIL divider_gap1: gap=%0d required=%0d", rises[1] - rises[0], 3 * FRAME);
      end
      if (rises[2] - rises[1] != 3 * FRAME) begin
        failures++;
        $display("FAIL divider_gap2: gap=%0d required=%0d", rises[2] - rises[1], 3 * FRAME);
      end
    end
  endtask

  task automatic test_pause;
    int n = 0;
    int n1 = 0;
    logic prev = 1'b0;
    logic prev1 = 1'b0;
    btnC = 1'b1;
    repeat (20) @(negedge clk);
    btnC = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (paused !== 1'b1 || paused1 !== 1'b1) begin
      failures++;
      $display("FAIL pause_on: paused=%b paused1=%b required=1", paused, paused1);
    end
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      if (move && !prev) n++;
      if (move1 && !prev1) n1++;
      prev = move;
      prev1 = move1;
    end
    checks++;
    if (n != 0 || n1 != 0 || paused !== 1'b1) begin
      failures++;
      $display("FAIL pause_suppress: moves=%0d moves1=%0d paused=%b required=0,0,1", n, n1, paused);
    end
    btnC = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (paused !== 1'b0) begin
      failures++;
      $display("FAIL pause_off: paused=%b required=0", paused);
    end
    goto_raster(0, 0);
    n = 0; n1 = 0; prev = move; prev1 = move1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      if (move && !prev) n++;
      if (move1 && !prev1) n1++;
      prev = move;
      prev1 = move1;
    end
    checks++;
    if (n != 1 || n1 != 3) begin
      failures++;
      $display("FAIL pause_resume: moves=%0d moves1=%0d required=1,3", n, n1);
    end
    btnC = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (paused !== 1'b0 || paused1 !== 1'b0) begin
      failures++;
      $display("FAIL pause_held: paused=%b paused1=%b required=0", paused, paused1);
    end
  endtask

  task automatic test_reset_mid;
    btnR = 1'b1;
    goto_raster(2, 0);
    goto_raster(VT / 2, 0);
    goto_raster(0, 1);
    goto_raster(5, 7);
    checks++;
    if (mR !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: mR=%b required=1", mR);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (got !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset_async: outputs=%b required=%b", got, 12'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    btnR = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (got !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset_after: outputs=%b required=%b", got, 12'd0);
    end
  endtask

  initial begin
    #100_000_0;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_move();
    test_debounce();
    test_frame_latch();
    test_opposing();
    test_random();
    test_divider();
    test_pause();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
